// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, Nk/Nr lookups, rcon stepping
// and the key-schedule controller states.
package aes_pkg;

    localparam logic [1:0] KEY_128     = 2'b00;
    localparam logic [1:0] KEY_192     = 2'b01;
    localparam logic [1:0] KEY_256     = 2'b10;
    localparam logic [1:0] KEY_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_DRAIN
    } state_e;

    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            KEY_128: return 4'd4;
            KEY_192: return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_128: return 4'd10;
            KEY_192: return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule: one expanded word per cycle,
// packed four at a time into round keys handed out over valid/ready.
module key_schedule_seq
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*MAX_NK-1:0]  key_in,
    input  logic                  rk_ready,
    output logic                  rk_valid,
    output logic [127:0]          rk_data,
    output logic [3:0]            rk_round,
    output logic                  rk_last,
    output logic                  busy,
    output logic                  err
);

    localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

    state_e        state_q, state_d;
    logic [3:0]    nk_q, nk_d, nr_q, nr_d;
    logic [31:0]   key_q [8];
    logic [31:0]   key_d [8];
    logic [31:0]   key_word [8];
    logic [31:0]   win_q [8];
    logic [31:0]   win_d [8];
    logic [5:0]    i_q, i_d;
    logic [2:0]    mod_q, mod_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [3:0]    round_q, round_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [95:0]   stage_q, stage_d;
    logic          rk_valid_q, rk_valid_d;
    logic [127:0]  rk_data_q, rk_data_d;
    logic [3:0]    rk_round_q, rk_round_d;
    logic          rk_last_q, rk_last_d;
    logic          err_q, err_d;

    logic [31:0]   temp, sub_in, sub_out, mixed, new_word;
    logic [5:0]    last_idx;
    logic          start_ok, handshake, advance;

    for (genvar k = 0; k < 8; k++) begin : g_key_word
        if (k < MAX_NK) begin : g_used
            assign key_word[k] = key_in[32*MAX_NK-1-32*k -: 32];
        end else begin : g_pad
            assign key_word[k] = '0;
        end
    end

    // RotWord only feeds the S-boxes on the once-per-Nk rcon step.
    assign temp   = win_q[0];
    assign sub_in = (mod_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*b +: 8]),
            .out_byte (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        mixed = temp;
        if (mod_q == 3'd0) begin
            mixed = sub_out ^ {rcon_q, 24'h0};
        end else if (nk_q == 4'd8 && mod_q == 3'd4) begin
            mixed = sub_out;
        end
        if (i_q < {2'b00, nk_q}) begin
            new_word = key_q[i_q[2:0]];
        end else begin
            new_word = win_q[nk_q[2:0] - 3'd1] ^ mixed;
        end
    end

    assign last_idx  = {nr_q, 2'b00} + 6'd3;
    assign start_ok  = (key_len != KEY_ILLEGAL) && (nk_of(key_len) <= MAX_NK_W);
    assign handshake = rk_valid_q && rk_ready;
    assign advance   = (state_q == ST_GEN) && (!rk_valid_q || rk_ready);

    always_comb begin
        state_d    = state_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        key_d      = key_q;
        win_d      = win_q;
        i_d        = i_q;
        mod_d      = mod_q;
        cnt_d      = cnt_q;
        round_d    = round_q;
        rcon_d     = rcon_q;
        stage_d    = stage_q;
        rk_valid_d = rk_valid_q;
        rk_data_d  = rk_data_q;
        rk_round_d = rk_round_q;
        rk_last_d  = rk_last_q;
        err_d      = 1'b0;

        if (handshake) begin
            rk_valid_d = 1'b0;
            rk_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        state_d = ST_GEN;
                        nk_d    = nk_of(key_len);
                        nr_d    = nr_of(key_len);
                        key_d   = key_word;
                        i_d     = '0;
                        mod_d   = '0;
                        cnt_d   = '0;
                        round_d = '0;
                        rcon_d  = 8'h01;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GEN: begin
                if (advance) begin
                    win_d[0] = new_word;
                    for (int k = 1; k < 8; k++) begin
                        win_d[k] = win_q[k-1];
                    end
                    i_d   = i_q + 6'd1;
                    mod_d = (mod_q == nk_q[2:0] - 3'd1) ? 3'd0 : mod_q + 3'd1;
                    if (i_q >= {2'b00, nk_q} && mod_q == 3'd0) begin
                        rcon_d = xtime(rcon_q);
                    end
                    cnt_d = cnt_q + 2'd1;
                    // The fourth word bypasses staging straight into the output register.
                    if (cnt_q == 2'd3) begin
                        rk_valid_d = 1'b1;
                        rk_data_d  = {stage_q, new_word};
                        rk_round_d = round_q;
                        rk_last_d  = (round_q == nr_q);
                        round_d    = round_q + 4'd1;
                    end else begin
                        stage_d = {stage_q[63:0], new_word};
                    end
                    if (i_q == last_idx) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (handshake) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            nk_q       <= '0;
            nr_q       <= '0;
            for (int k = 0; k < 8; k++) begin
                key_q[k] <= '0;
                win_q[k] <= '0;
            end
            i_q        <= '0;
            mod_q      <= '0;
            cnt_q      <= '0;
            round_q    <= '0;
            rcon_q     <= 8'h01;
            stage_q    <= '0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_round_q <= '0;
            rk_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            key_q      <= key_d;
            win_q      <= win_d;
            i_q        <= i_d;
            mod_q      <= mod_d;
            cnt_q      <= cnt_d;
            round_q    <= round_d;
            rcon_q     <= rcon_d;
            stage_q    <= stage_d;
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_round_q <= rk_round_d;
            rk_last_q  <= rk_last_d;
            err_q      <= err_d;
        end
    end

    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_round = rk_round_q;
    assign rk_last  = rk_last_q;
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq: a GF(2^8)-based reference key
// expansion predicts every round key, checked on each valid cycle.
module tb_key_schedule_seq;

    localparam int MAX_NK = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;
    logic         err;

    int           checks = 0;
    int           failures = 0;
    int           exp_round = 0;
    logic [127:0] exp_q [$];
    logic [127:0] model_rk [15];
    logic [127:0] captured [15];
    logic [7:0]   sbox_tab [256];

    always #5 clk = ~clk;

    key_schedule_seq #(.MAX_NK(MAX_NK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .rk_last  (rk_last),
        .busy     (busy),
        .err      (err)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse, then the affine map.
    function automatic logic [7:0] sboxFromMath(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] v);
        return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
    endfunction

    task automatic buildModel(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        rc = 8'h01;
        nr = nk + 6;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subWord(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // Compare process: every valid cycle must present the next predicted key.
    initial begin
        logic         stall_prev;
        logic [127:0] prev_data;
        logic [3:0]   prev_round;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_round = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            if (stall_prev) begin
                checkOutput("stall_valid_held", 128'(rk_valid), 128'(1));
                if (rk_valid) begin
                    checkOutput("stall_data_stable", rk_data, prev_data);
                    checkOutput("stall_round_stable", 128'(rk_round), 128'(prev_round));
                end
            end
            if (rk_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_key actual=round %0d required=no key", rk_round);
                end else begin
                    checkOutput("rk_data", rk_data, exp_q[0]);
                    checkOutput("rk_round", 128'(rk_round), 128'(exp_round));
                    checkOutput("rk_last", 128'(rk_last), 128'(exp_q.size() == 1));
                    if (rk_ready) begin
                        if (exp_round < 15) captured[exp_round] = rk_data;
                        void'(exp_q.pop_front());
                        exp_round++;
                    end
                end
            end
            stall_prev = rk_valid && !rk_ready;
            prev_data  = rk_data;
            prev_round = rk_round;
        end
    end

    // Runs one expansion starting #1 after a posedge with the DUT idle.
    task automatic applyStimulus(input logic [1:0] len, input logic [255:0] key, input bit rand_ready,
                                 input bit inject_start, input int reset_round,
                                 output int first_cyc, output int last_cyc);
        int nk;
        int cyc;
        first_cyc = -1;
        last_cyc  = -1;
        nk = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
        buildModel(key, nk);
        exp_q.delete();
        exp_round = 0;
        for (int r = 0; r <= nk + 6; r++) exp_q.push_back(model_rk[r]);
        start   = 1'b1;
        key_len = len;
        key_in  = key;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        checkOutput("busy_after_accept", 128'(busy), 128'(1));
        cyc = 0;
        forever begin
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject_start && cyc == 8) begin
                start   = 1'b1;
                key_len = 2'b00;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (inject_start && cyc == 9) checkOutput("busy_start_no_err", 128'(err), 128'(0));
            if (rk_valid && first_cyc < 0) first_cyc = cyc;
            if (rk_valid && rk_last && last_cyc < 0) last_cyc = cyc;
            if (reset_round >= 0 && rk_valid && int'(rk_round) == reset_round) begin
                rst_n = 1'b0;
                #1;
                checkOutput("midreset_valid", 128'(rk_valid), 128'(0));
                checkOutput("midreset_data", rk_data, 128'(0));
                checkOutput("midreset_round", 128'(rk_round), 128'(0));
                checkOutput("midreset_last", 128'(rk_last), 128'(0));
                checkOutput("midreset_busy", 128'(busy), 128'(0));
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            if (!busy) break;
            if (cyc >= 400) begin
                checks++;
                failures++;
                $display("[TB] FAIL schedule_timeout actual=still busy required=idle within 400 cycles");
                break;
            end
        end
        checkOutput("queue_drained", 128'(exp_q.size()), 128'(0));
        checkOutput("idle_no_valid", 128'(rk_valid), 128'(0));
    endtask

    task automatic applyIllegal();
        start   = 1'b1;
        key_len = 2'b11;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("illegal_err_pulse", 128'(err), 128'(1));
        checkOutput("illegal_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;
        checkOutput("illegal_err_clears", 128'(err), 128'(0));
        checkOutput("illegal_valid", 128'(rk_valid), 128'(0));
    endtask

    initial begin
        int first_cyc, last_cyc;
        logic [255:0] k128, k192, k256, rkey;
        logic [1:0] rlen;

        for (int v = 0; v < 256; v++) sbox_tab[v] = sboxFromMath(8'(v));

        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_len  = 2'b00;
        key_in   = '0;
        #12;
        checkOutput("reset_valid", 128'(rk_valid), 128'(0));
        checkOutput("reset_data", rk_data, 128'(0));
        checkOutput("reset_round", 128'(rk_round), 128'(0));
        checkOutput("reset_last", 128'(rk_last), 128'(0));
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_err", 128'(err), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

        applyStimulus(2'b00, k128, 1'b0, 1'b0, -1, first_cyc, last_cyc);
        checkOutput("model_aes128_r1", model_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("model_aes128_r10", model_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        checkOutput("aes128_r0", captured[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        checkOutput("aes128_r1", captured[1], 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("aes128_r10", captured[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        checkOutput("aes128_first_latency", 128'(first_cyc), 128'(4));
        checkOutput("aes128_total_cycles", 128'(last_cyc), 128'(44));

        applyStimulus(2'b01, k192, 1'b0, 1'b0, -1, first_cyc, last_cyc);
        checkOutput("model_aes192_r12", model_rk[12], 128'he98ba06f448c773c8ecc720401002202);
        checkOutput("aes192_r1", captured[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        checkOutput("aes192_r12", captured[12], 128'he98ba06f448c773c8ecc720401002202);
        checkOutput("aes192_total_cycles", 128'(last_cyc), 128'(52));

        applyStimulus(2'b10, k256, 1'b0, 1'b0, -1, first_cyc, last_cyc);
        checkOutput("model_aes256_r2", model_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        checkOutput("aes256_r2", captured[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        checkOutput("aes256_r14", captured[14], 128'hfe4890d1e6188d0b046df344706c631e);
        checkOutput("aes256_total_cycles", 128'(last_cyc), 128'(60));

        applyStimulus(2'b00, k128, 1'b1, 1'b0, -1, first_cyc, last_cyc);
        checkOutput("aes128_stall_r10", captured[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int n = 0; n < 6; n++) begin
            rlen = 2'($urandom_range(0, 2));
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            applyStimulus(rlen, rkey, n[0], 1'b0, -1, first_cyc, last_cyc);
        end

        applyIllegal();

        applyStimulus(2'b00, k128, 1'b0, 1'b1, -1, first_cyc, last_cyc);
        checkOutput("busy_start_r10", captured[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        applyStimulus(2'b10, k256, 1'b0, 1'b0, 5, first_cyc, last_cyc);
        applyStimulus(2'b00, k128, 1'b0, 1'b0, -1, first_cyc, last_cyc);
        checkOutput("post_reset_latency", 128'(first_cyc), 128'(4));
        checkOutput("post_reset_r0", captured[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        checkOutput("post_reset_r1", captured[1], 128'ha0fafe1788542cb123a339392a6c7605);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_schedule_seq.md
# key_schedule_seq

Sequential, multi-mode AES key-schedule generator. It replaces the single-step combinational expansion with a block that streams the complete round-key schedule for AES-128, AES-192 and AES-256. The key length is selected per operation, and each 128-bit round key is delivered over a valid/ready handshake. It sits between the key register file and the round pipeline of the cipher core.

## Interface
- MAX_NK, 8, largest supported key length in 32-bit words (4, 6 or 8); sizes the word window and the key_in width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin an expansion; sampled only in IDLE.
- key_len  in  2  00 = 128-bit (Nk=4, Nr=10), 01 = 192-bit (Nk=6, Nr=12), 10 = 256-bit (Nk=8, Nr=14), 11 = illegal.
- key_in  in  32*MAX_NK  cipher key, MSB-aligned; word 0 = key_in[32*MAX_NK-1 -: 32]; sampled at start.
- rk_ready  in  1  consumer accepts rk_data.
- rk_valid  out  1  rk_data holds a complete round key.
- rk_data  out  128  round key; word 0 in bits [127:96].
- rk_round  out  4  round index 0..Nr of rk_data.
- rk_last  out  1  rk_data is round Nr.
- busy  out  1  expansion in progress or round key pending.
- err  out  1  one-cycle pulse when the start is rejected.

## Operation
- States:
  - IDLE → GEN on an accepted start.
  - GEN → DRAIN after the final word w[4(Nr+1)-1] is produced.
  - DRAIN → IDLE when the last round key is accepted.
- Start acceptance:
  - start is accepted in IDLE only.
  - A start with key_len = 11, or with Nk > MAX_NK, is rejected: err pulses for one cycle and the state stays IDLE.
  - start while busy is ignored, with no err.
- On accept:
  - Latch Nk, Nr and key_in.
  - Clear word index i, staging count and round counter.
  - Set rcon = 0x01.
- Word generation in GEN: one word per advancing cycle.
  - i < Nk: w[i] = key word i.
  - else temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon), i.e. shift left, XOR 0x1B on carry.
  - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
- Word window:
  - An 8-word shift register holds the last MAX_NK words; the new word shifts into slot 0.
  - w[i-1] = slot 0; w[i-Nk] = slot Nk-1.
  - i mod Nk is tracked by a wrap counter, not a divider.
- Staging:
  - Words are collected four at a time into a 128-bit staging register.
  - When the fourth word lands, the output register loads and rk_valid sets.
- Advance condition: the generator advances when the output register is empty, or when rk_valid & rk_ready occur in the same cycle (full throughput).
- Backpressure: while rk_valid & !rk_ready with staging about to complete, generation stalls and the staging and output registers hold.
- Reset mid-operation: all state returns to reset values immediately and the partial schedule is discarded.

## Timing
- Reset values:
  - rk_valid = 0, rk_data = 0, rk_round = 0, rk_last = 0, busy = 0, err = 0.
  - State = IDLE, rcon = 0x01.
- busy rises on the cycle after start is accepted and falls on the cycle after the last handshake.
- Latency: round key 0 is valid 4 cycles after the start-accept edge; round key r is valid at 4(r+1) cycles with no backpressure.
- Full schedule with rk_ready held high:
  - 44 cycles for AES-128, 52 for AES-192, 60 for AES-256.
  - Then IDLE on the cycle after the last handshake.
- rk_data, rk_round and rk_last are stable while rk_valid & !rk_ready.
- rk_valid never drops without a handshake except on reset.
- err asserts on the cycle after the rejected start.

## Structure
- aes_pkg holds:
  - key_len encodings, and the Nk and Nr lookup functions.
  - The rcon xtime function.
  - The state enum.
- Sub-module aes_sbox (combinational, 8-bit, forward S-box), instantiated 4× for SubWord. The cipher datapath reuses the same module.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1:
  - Round 0 = key.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last = 1.
  - 44 cycles total.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - Round 1 = 62f8ead2522c6b7bfe0c91f72402f5a5.
  - Round 12 = e98ba06f448c773c8ecc720401002202.
  - 52 cycles total.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - Round 2 = 9ba354118e6925afa51a8b5f2067fcde.
  - Round 14 = fe4890d1e6188d0b046df344706c631e.
- AES-128 with rk_ready toggling randomly:
  - The identical 11-key sequence is produced.
  - rk_data is stable under stall.
  - No key is dropped or duplicated.
- start with key_len = 11 → err pulse, busy stays 0. start while busy → ignored, and the schedule is unaffected.
- rst_n asserted during round 5 of AES-256 → outputs go to reset values at once. A new AES-128 start afterwards yields the correct round 0 at 4 cycles, with rcon restarted at 0x01.
